// File: rtl/ahb_master_port.sv
// rtl/ahb_master_port.sv - AHB master bus engine: command in, arbitrated burst out
//
// Purpose: accepts one burst command at a time from local logic, requests the
// bus, drives NONSEQ/SEQ address phases with INCR or WRAP addressing, moves
// write/read data, and reports completion. It handles loss of grant by
// re-requesting and resuming as INCR, and ends a burst on a two-cycle ERROR.
//
// Ports:
//   Hclk, Hresetn                     clock, async active-low reset
//   cmd_valid/cmd_ready               command handshake
//   cmd_addr/write/burst/size/len     command fields
//   wdata, wdata_pop                  write beat source and consume strobe
//   rdata, rdata_valid                read beat sink
//   done, err                         completion pulse, error qualifier
//   Hbusreq, Hgrant                   arbitration handshake
//   Hready, Hresp, Hrdata             slave response
//   Haddr/Htrans/Hwrite/Hburst/Hsize  address and control
//   Hwdata                            write data
module ahb_master_port #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  Hclk,
  input  logic                  Hresetn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic                  cmd_write,
  input  logic [2:0]            cmd_burst,
  input  logic [2:0]            cmd_size,
  input  logic [4:0]            cmd_len,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  wdata_pop,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rdata_valid,
  output logic                  done,
  output logic                  err,
  output logic                  Hbusreq,
  input  logic                  Hgrant,
  input  logic                  Hready,
  input  logic                  Hresp,
  input  logic [DATA_WIDTH-1:0] Hrdata,
  output logic [ADDR_WIDTH-1:0] Haddr,
  output logic [1:0]            Htrans,
  output logic                  Hwrite,
  output logic [2:0]            Hburst,
  output logic [2:0]            Hsize,
  output logic [DATA_WIDTH-1:0] Hwdata
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_BUS   = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_NONSEQ = 2'b10;
  localparam logic [1:0] TR_SEQ    = 2'b11;

  state_t state, state_nxt;

  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  write_q;
  logic [2:0]            burst_q;
  logic [2:0]            size_q;
  logic                  wrap_q;      // wrap arithmetic survives the switch to INCR on re-grant
  logic [1:0]            wrap_sel_q;  // 1: 4 beats, 2: 8 beats, 3: 16 beats
  logic [4:0]            beats_left;
  logic                  first_q;     // next address phase is NONSEQ
  logic                  dphase_q;    // a data phase is outstanding
  logic                  err_q;       // first ERROR cycle seen, waiting for the second

  logic                  accept;
  logic                  grant_lost;
  logic                  err_first;
  logic                  dcomplete;
  logic                  last_beat;
  logic [4:0]            cmd_beats;

  logic [ADDR_WIDTH-1:0] incr;
  logic [ADDR_WIDTH-1:0] wrap_mask;
  logic [ADDR_WIDTH-1:0] addr_sum;
  logic [ADDR_WIDTH-1:0] addr_nxt;

  assign last_beat  = (beats_left == 5'd1);
  assign accept     = (state == ST_BUS) && !err_q && Hready && Hgrant;
  assign grant_lost = (state == ST_BUS) && !err_q && Hready && !Hgrant;
  assign err_first  = dphase_q && !err_q && Hresp && !Hready;
  assign dcomplete  = dphase_q && !err_q && Hready;

  always_comb begin
    cmd_beats = 5'd16;
    case (cmd_burst[2:1])
      2'b00:   cmd_beats = cmd_burst[0] ? ((cmd_len == 5'd0) ? 5'd16 : cmd_len) : 5'd1;
      2'b01:   cmd_beats = 5'd4;
      2'b10:   cmd_beats = 5'd8;
      default: cmd_beats = 5'd16;
    endcase
  end

  // Wrapping keeps the bits above the block size and increments the rest modulo the block.
  always_comb begin
    incr = ADDR_WIDTH'(1) << size_q;
    case (wrap_sel_q)
      2'd1:    wrap_mask = (incr << 2) - ADDR_WIDTH'(1);
      2'd2:    wrap_mask = (incr << 3) - ADDR_WIDTH'(1);
      default: wrap_mask = (incr << 4) - ADDR_WIDTH'(1);
    endcase
    addr_sum = addr_q + incr;
    addr_nxt = wrap_q ? ((addr_q & ~wrap_mask) | (addr_sum & wrap_mask)) : addr_sum;
  end

  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (cmd_valid) state_nxt = ST_REQ;
      ST_REQ:   if (Hgrant && Hready) state_nxt = ST_BUS;
      ST_BUS: begin
        if (err_q) begin
          if (Hready) state_nxt = ST_IDLE;
        end else if (accept && last_beat) begin
          state_nxt = ST_DRAIN;
        end else if (grant_lost) begin
          state_nxt = ST_REQ;
        end
      end
      ST_DRAIN: if (Hready) state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready   = (state == ST_IDLE);
    Hbusreq     = 1'b0;
    Htrans      = TR_IDLE;
    done        = 1'b0;
    err         = 1'b0;
    wdata_pop   = dcomplete && write_q;
    rdata_valid = dcomplete && !write_q;
    case (state)
      ST_REQ: Hbusreq = 1'b1;
      ST_BUS: begin
        if (!err_q) begin
          Hbusreq = (beats_left > 5'd1);
          Htrans  = first_q ? TR_NONSEQ : TR_SEQ;
        end else if (Hready) begin
          done = 1'b1;
          err  = 1'b1;
        end
      end
      ST_DRAIN: begin
        done = Hready;
        err  = Hready && err_q;
      end
      default: ;
    endcase
  end

  assign Haddr  = addr_q;
  assign Hwrite = write_q;
  assign Hburst = burst_q;
  assign Hsize  = size_q;
  assign Hwdata = (dphase_q && write_q) ? wdata : '0;
  assign rdata  = Hrdata;

  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      addr_q     <= '0;
      write_q    <= 1'b0;
      burst_q    <= 3'b000;
      size_q     <= 3'b000;
      wrap_q     <= 1'b0;
      wrap_sel_q <= 2'd0;
      beats_left <= 5'd0;
      first_q    <= 1'b0;
      dphase_q   <= 1'b0;
      err_q      <= 1'b0;
    end else if (state == ST_IDLE && cmd_valid) begin
      addr_q     <= cmd_addr;
      write_q    <= cmd_write;
      burst_q    <= cmd_burst;
      size_q     <= cmd_size;
      wrap_q     <= (cmd_burst != 3'b000) && !cmd_burst[0];
      wrap_sel_q <= cmd_burst[2:1];
      beats_left <= cmd_beats;
      first_q    <= 1'b1;
      dphase_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      if (accept) begin
        addr_q     <= addr_nxt;
        beats_left <= beats_left - 5'd1;
        first_q    <= 1'b0;
        dphase_q   <= 1'b1;
      end else if (Hready) begin
        dphase_q   <= 1'b0;
      end
      // Resume after re-grant as an undefined-length burst from the pending address.
      if (grant_lost) begin
        first_q <= 1'b1;
        burst_q <= 3'b001;
      end
      if (err_first) begin
        err_q <= 1'b1;
      end else if (err_q && Hready) begin
        err_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ahb_master_port.sv
// tb/tb_ahb_master_port.sv - directed self-checking bench for ahb_master_port
module tb_ahb_master_port;

  logic        Hclk;
  logic        Hresetn;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_addr;
  logic        cmd_write;
  logic [2:0]  cmd_burst;
  logic [2:0]  cmd_size;
  logic [4:0]  cmd_len;
  logic [31:0] wdata;
  logic        wdata_pop;
  logic [31:0] rdata;
  logic        rdata_valid;
  logic        done;
  logic        err;
  logic        Hbusreq;
  logic        Hgrant;
  logic        Hready;
  logic        Hresp;
  logic [31:0] Hrdata;
  logic [31:0] Haddr;
  logic [1:0]  Htrans;
  logic        Hwrite;
  logic [2:0]  Hburst;
  logic [2:0]  Hsize;
  logic [31:0] Hwdata;

  int checks = 0;
  int errors = 0;

  logic       cur_write;
  logic [2:0] cur_size;
  logic [2:0] exp_burst;

  localparam logic [1:0] NS = 2'b10;
  localparam logic [1:0] SQ = 2'b11;
  localparam logic [1:0] ID = 2'b00;

  logic [31:0] wrap_addrs [8] = '{32'h34, 32'h38, 32'h3C, 32'h20,
                                  32'h24, 32'h28, 32'h2C, 32'h30};

  ahb_master_port #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .Hclk        (Hclk),
    .Hresetn     (Hresetn),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_addr    (cmd_addr),
    .cmd_write   (cmd_write),
    .cmd_burst   (cmd_burst),
    .cmd_size    (cmd_size),
    .cmd_len     (cmd_len),
    .wdata       (wdata),
    .wdata_pop   (wdata_pop),
    .rdata       (rdata),
    .rdata_valid (rdata_valid),
    .done        (done),
    .err         (err),
    .Hbusreq     (Hbusreq),
    .Hgrant      (Hgrant),
    .Hready      (Hready),
    .Hresp       (Hresp),
    .Hrdata      (Hrdata),
    .Haddr       (Haddr),
    .Htrans      (Htrans),
    .Hwrite      (Hwrite),
    .Hburst      (Hburst),
    .Hsize       (Hsize),
    .Hwdata      (Hwdata)
  );

  initial Hclk = 1'b0;
  always #5 Hclk = ~Hclk;

  task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_value({tag, " Htrans"},      Htrans,      2'b00);
    check_value({tag, " Haddr"},       Haddr,       32'h0);
    check_value({tag, " Hburst"},      Hburst,      3'b000);
    check_value({tag, " Hsize"},       Hsize,       3'b000);
    check_value({tag, " Hwrite"},      Hwrite,      1'b0);
    check_value({tag, " Hbusreq"},     Hbusreq,     1'b0);
    check_value({tag, " wdata_pop"},   wdata_pop,   1'b0);
    check_value({tag, " rdata_valid"}, rdata_valid, 1'b0);
    check_value({tag, " done"},        done,        1'b0);
    check_value({tag, " err"},         err,         1'b0);
    check_value({tag, " cmd_ready"},   cmd_ready,   1'b1);
  endtask

  // Entered and left at posedge+1: offers a command for one cycle (cycle 0).
  task automatic issue(input logic [31:0] a, input logic w, input logic [2:0] b,
                       input logic [2:0] s, input logic [4:0] l);
    cmd_valid = 1'b1;
    cmd_addr  = a;
    cmd_write = w;
    cmd_burst = b;
    cmd_size  = s;
    cmd_len   = l;
    cur_write = w;
    cur_size  = s;
    exp_burst = b;
    Hgrant    = 1'b1;
    Hready    = 1'b1;
    Hresp     = 1'b0;
    #2;
    check_value("issue cmd_ready", cmd_ready, 1'b1);
    check_value("issue Htrans", Htrans, ID);
    check_value("issue Hbusreq", Hbusreq, 1'b0);
    @(posedge Hclk);
    #1;
    cmd_valid = 1'b0;
  endtask

  // One bus cycle: drive slave-side inputs, then compare every output of interest.
  task automatic cyc(input logic rdy, input logic gnt, input logic rsp,
                     input logic [1:0] e_trans, input logic [31:0] e_addr,
                     input logic e_req, input logic e_dat, input logic e_done, input logic e_err);
    logic [31:0] rd;
    logic [31:0] wd;
    rd     = $urandom;
    wd     = $urandom;
    Hready = rdy;
    Hgrant = gnt;
    Hresp  = rsp;
    Hrdata = rd;
    wdata  = wd;
    #2;
    check_value("Htrans", Htrans, e_trans);
    if (e_trans != ID) begin
      check_value("Haddr", Haddr, e_addr);
      check_value("Hburst", Hburst, exp_burst);
      check_value("Hwrite", Hwrite, cur_write);
      check_value("Hsize", Hsize, cur_size);
    end
    check_value("Hbusreq", Hbusreq, e_req);
    check_value("wdata_pop", wdata_pop, cur_write && e_dat);
    check_value("rdata_valid", rdata_valid, !cur_write && e_dat);
    if (e_dat) begin
      if (cur_write) check_value("Hwdata", Hwdata, wd);
      else           check_value("rdata", rdata, rd);
    end
    check_value("done", done, e_done);
    check_value("err", err, e_err);
    @(posedge Hclk);
    #1;
  endtask

  task automatic test_single();
    issue(32'h100, 1'b1, 3'b000, 3'd2, 5'd0);
    cyc(1, 1, 0, ID, 32'h0,   1, 0, 0, 0);
    cyc(1, 1, 0, NS, 32'h100, 0, 0, 0, 0);
    cyc(1, 1, 0, ID, 32'h0,   0, 1, 1, 0);
    #2;
    check_value("single cmd_ready after done", cmd_ready, 1'b1);
    check_value("single done cleared", done, 1'b0);
    @(posedge Hclk);
    #1;
  endtask

  initial begin
    Hresetn   = 1'b0;
    cmd_valid = 1'b0;
    cmd_addr  = '0;
    cmd_write = 1'b0;
    cmd_burst = '0;
    cmd_size  = '0;
    cmd_len   = '0;
    wdata     = '0;
    Hgrant    = 1'b0;
    Hready    = 1'b1;
    Hresp     = 1'b0;
    Hrdata    = '0;
    cur_write = 1'b0;
    cur_size  = 3'd0;
    exp_burst = 3'd0;

    repeat (2) @(posedge Hclk);
    #1;
    check_reset_outputs("reset");
    Hresetn = 1'b1;
    @(posedge Hclk);
    #1;

    // SINGLE write
    test_single();

    // INCR4 read with one wait state while beat 2's address is driven
    issue(32'h200, 1'b0, 3'b011, 3'd2, 5'd0);
    cyc(1, 1, 0, ID, 32'h0,   1, 0, 0, 0);
    cyc(1, 1, 0, NS, 32'h200, 1, 0, 0, 0);
    cyc(0, 1, 0, SQ, 32'h204, 1, 0, 0, 0);
    cyc(1, 1, 0, SQ, 32'h204, 1, 1, 0, 0);
    cyc(1, 1, 0, SQ, 32'h208, 1, 1, 0, 0);
    cyc(1, 1, 0, SQ, 32'h20C, 0, 1, 0, 0);
    cyc(1, 1, 0, ID, 32'h0,   0, 1, 1, 0);

    // WRAP8 read at 0x34
    issue(32'h34, 1'b0, 3'b100, 3'd2, 5'd0);
    cyc(1, 1, 0, ID, 32'h0, 1, 0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      cyc(1, 1, 0, (i == 0) ? NS : SQ, wrap_addrs[i], (i < 7), (i > 0), 0, 0);
    end
    cyc(1, 1, 0, ID, 32'h0, 0, 1, 1, 0);

    // INCR len 6 with grant loss after beat 3, re-grant 4 cycles later
    issue(32'h400, 1'b0, 3'b001, 3'd2, 5'd6);
    cyc(1, 1, 0, ID, 32'h0,   1, 0, 0, 0);
    cyc(1, 1, 0, NS, 32'h400, 1, 0, 0, 0);
    cyc(1, 1, 0, SQ, 32'h404, 1, 1, 0, 0);
    cyc(1, 1, 0, SQ, 32'h408, 1, 1, 0, 0);
    cyc(1, 0, 0, SQ, 32'h40C, 1, 1, 0, 0);
    repeat (3) cyc(1, 0, 0, ID, 32'h0, 1, 0, 0, 0);
    cyc(1, 1, 0, ID, 32'h0,   1, 0, 0, 0);
    cyc(1, 1, 0, NS, 32'h40C, 1, 0, 0, 0);
    cyc(1, 1, 0, SQ, 32'h410, 1, 1, 0, 0);
    cyc(1, 1, 0, SQ, 32'h414, 0, 1, 0, 0);
    cyc(1, 1, 0, ID, 32'h0,   0, 1, 1, 0);

    // INCR8 write, ERROR on beat 3
    issue(32'h500, 1'b1, 3'b101, 3'd2, 5'd0);
    cyc(1, 1, 0, ID, 32'h0,   1, 0, 0, 0);
    cyc(1, 1, 0, NS, 32'h500, 1, 0, 0, 0);
    cyc(1, 1, 0, SQ, 32'h504, 1, 1, 0, 0);
    cyc(1, 1, 0, SQ, 32'h508, 1, 1, 0, 0);
    cyc(0, 1, 1, SQ, 32'h50C, 1, 0, 0, 0);
    cyc(1, 1, 1, ID, 32'h0,   0, 0, 1, 1);
    Hresp = 1'b0;
    #2;
    check_value("error cmd_ready after done", cmd_ready, 1'b1);
    check_value("error Htrans after done", Htrans, ID);
    check_value("error done cleared", done, 1'b0);
    @(posedge Hclk);
    #1;

    // Asynchronous reset in the middle of an INCR4 write
    issue(32'h600, 1'b1, 3'b011, 3'd2, 5'd0);
    cyc(1, 1, 0, ID, 32'h0,   1, 0, 0, 0);
    cyc(1, 1, 0, NS, 32'h600, 1, 0, 0, 0);
    Hready = 1'b1;
    #2;
    check_value("midreset Htrans before", Htrans, SQ);
    Hresetn = 1'b0;
    #1;
    check_reset_outputs("midreset");
    @(posedge Hclk);
    #1;
    Hresetn = 1'b1;
    @(posedge Hclk);
    #1;
    test_single();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
